fft_mem_sequencer: RTL and testbench

- Parametrised multi-channel sequencer between the FFT butterfly datapath and a single-port Avalon-style memory with acknowledge.
- On a single start pulse it captures RD_CH read addresses, or WR_CH write address/data pairs, and issues them to memory one access at a time in channel order.
- It waits for mem_ack on every access, then raises done for one cycle.
- It sits between the butterfly controller and the on-chip RAM system, replacing fixed A/B/twiddle sequencing with configurable channel counts and widths.

---
 rtl/fft_mem_sequencer_if.sv | 31 +++
 rtl/fft_mem_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_fft_mem_sequencer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_mem_sequencer_if.sv
// Memory-side bus of the FFT memory sequencer: single-port Avalon-style
// memory with per-access acknowledge.
//   master modport (sequencer): drives mem_addr (byte address), mem_byte_enable,
//                               mem_read, mem_write, mem_wdata;
//                               receives mem_ack, mem_rdata.
//   slave modport  (memory)   : the mirror image.
interface fft_mem_sequencer_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 11
);
    localparam int unsigned BS   = $clog2(DATA_W / 8);
    localparam int unsigned MA_W = ADDR_W + BS;

    logic [MA_W-1:0]       mem_addr;
    logic [DATA_W/8-1:0]   mem_byte_enable;
    logic                  mem_read;
    logic                  mem_write;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_ack;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (
        output mem_addr, mem_byte_enable, mem_read, mem_write, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_addr, mem_byte_enable, mem_read, mem_write, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/fft_mem_sequencer.sv
// Multi-channel sequencer between the FFT butterfly datapath and a single-port
// acknowledged memory. A start pulse snapshots RD_CH read addresses or WR_CH
// write address/data pairs; the accesses are then issued one at a time in
// channel order, each waiting for mem_ack, followed by a one-cycle done pulse.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   rd_start, wr_start  one-cycle start pulses (both at once -> err pulse)
//   rd_addr             RD_CH packed read word addresses
//   wr_addr, wr_data    WR_CH packed write word addresses / data
//   rd_data             RD_CH packed registered read results
//   busy, done, err     status (busy level, done / err one-cycle pulses)
//   mem                 memory bus (fft_mem_sequencer_if.master)
//
// Optional feature: define FFT_MEM_SEQ_TIMEOUT_EN to abort an access after
// TIMEOUT consecutive unacknowledged cycles (err pulse, return to IDLE).
module fft_mem_sequencer #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned RD_CH   = 3,
    parameter int unsigned WR_CH   = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rd_start,
    input  logic                    wr_start,
    input  logic [RD_CH*ADDR_W-1:0] rd_addr,
    input  logic [WR_CH*ADDR_W-1:0] wr_addr,
    input  logic [WR_CH*DATA_W-1:0] wr_data,
    output logic [RD_CH*DATA_W-1:0] rd_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    fft_mem_sequencer_if.master     mem
);

    localparam int unsigned BS     = $clog2(DATA_W / 8);
    localparam int unsigned MA_W   = ADDR_W + BS;
    localparam int unsigned MAX_CH = (RD_CH > WR_CH) ? RD_CH : WR_CH;
    localparam int unsigned IDX_W  = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;

    // Elaboration-time parameter sanity checks
    if (DATA_W < 8 || (DATA_W & (DATA_W - 1)) != 0) begin : g_bad_data_w
        $error("fft_mem_sequencer: DATA_W must be a power of two and >= 8");
    end
    if (RD_CH < 1 || WR_CH < 1) begin : g_bad_ch
        $error("fft_mem_sequencer: RD_CH and WR_CH must be >= 1");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("fft_mem_sequencer: TIMEOUT must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [RD_CH*ADDR_W-1:0] rd_snap_q;
    logic [WR_CH*ADDR_W-1:0] wa_snap_q;
    logic [WR_CH*DATA_W-1:0] wd_snap_q;
    logic [RD_CH*DATA_W-1:0] rd_data_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    err_q;

`ifdef FFT_MEM_SEQ_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
    logic [WAIT_W-1:0]       wait_q;
    logic                    expire_c;

    // Last unacknowledged cycle the memory is allowed before the abort
    assign expire_c = (wait_q == WAIT_W'(TIMEOUT - 1)) && !mem.mem_ack;
`endif

    // Word address to byte address: {word_addr, BS zero bits}
    function automatic logic [MA_W-1:0] byte_addr(input logic [ADDR_W-1:0] word);
        return MA_W'(word) << BS;
    endfunction

    // Sequencer FSM with registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            rd_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef FFT_MEM_SEQ_TIMEOUT_EN
            wait_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rd_start && wr_start) begin
                        err_q <= 1'b1;
                    end else if (rd_start) begin
                        rd_snap_q <= rd_addr;
                        idx_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_READ;
                    end else if (wr_start) begin
                        wa_snap_q <= wr_addr;
                        wd_snap_q <= wr_data;
                        idx_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_WRITE;
                    end
`ifdef FFT_MEM_SEQ_TIMEOUT_EN
                    wait_q <= '0;
`endif
                end

                ST_READ: begin
                    if (mem.mem_ack) begin
                        rd_data_q[DATA_W*int'(idx_q) +: DATA_W] <= mem.mem_rdata;
                        if (idx_q == IDX_W'(RD_CH - 1)) begin
                            idx_q   <= '0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
`ifdef FFT_MEM_SEQ_TIMEOUT_EN
                    if (mem.mem_ack) begin
                        wait_q <= '0;
                    end else if (expire_c) begin
                        wait_q  <= '0;
                        idx_q   <= '0;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
`endif
                end

                ST_WRITE: begin
                    if (mem.mem_ack) begin
                        if (idx_q == IDX_W'(WR_CH - 1)) begin
                            idx_q   <= '0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
`ifdef FFT_MEM_SEQ_TIMEOUT_EN
                    if (mem.mem_ack) begin
                        wait_q <= '0;
                    end else if (expire_c) begin
                        wait_q  <= '0;
                        idx_q   <= '0;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
`endif
                end

                ST_DONE: begin
                    // Starts arriving here are dropped on purpose
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory strobes/address/data decoded from state, idx and the snapshot
    always_comb begin
        mem.mem_read  = 1'b0;
        mem.mem_write = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        case (state_q)
            ST_READ: begin
                mem.mem_read = 1'b1;
                mem.mem_addr = byte_addr(rd_snap_q[ADDR_W*int'(idx_q) +: ADDR_W]);
            end
            ST_WRITE: begin
                mem.mem_write = 1'b1;
                mem.mem_addr  = byte_addr(wa_snap_q[ADDR_W*int'(idx_q) +: ADDR_W]);
                mem.mem_wdata = wd_snap_q[DATA_W*int'(idx_q) +: DATA_W];
            end
            default: begin
            end
        endcase
    end

    assign mem.mem_byte_enable = '1;
    assign rd_data             = rd_data_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign err                 = err_q;

endmodule

// File: tb/tb_fft_mem_sequencer.sv
// Self-checking bench for fft_mem_sequencer: table of transactions, a memory
// model with configurable ack stall that checks every access against a
// scoreboard queue, plus hand-written corner-case sequences.
module tb_fft_mem_sequencer;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned ADDR_W  = 11;
    localparam int unsigned RD_CH   = 3;
    localparam int unsigned WR_CH   = 2;
    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned BS      = 3;
    localparam int unsigned MA_W    = ADDR_W + BS;
    localparam int unsigned RDW     = RD_CH * DATA_W;

    localparam logic [63:0] V_DEAD = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] V_55AA = 64'h55AA_55AA_0F0F_F0F0;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    rd_start;
    logic                    wr_start;
    logic [RD_CH*ADDR_W-1:0] rd_addr;
    logic [WR_CH*ADDR_W-1:0] wr_addr;
    logic [WR_CH*DATA_W-1:0] wr_data;
    logic [RDW-1:0]          rd_data;
    logic                    busy;
    logic                    done;
    logic                    err;

    fft_mem_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem_if ();

    fft_mem_sequencer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .RD_CH  (RD_CH),
        .WR_CH  (WR_CH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rd_start(rd_start),
        .wr_start(wr_start),
        .rd_addr (rd_addr),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .mem     (mem_if.master)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [RDW-1:0] act,
                         input logic [RDW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard of expected memory accesses
    typedef struct packed {
        logic            wr;
        logic [MA_W-1:0] addr;
        logic [63:0]     wdata;
    } acc_t;

    acc_t        exp_q[$];
    logic [63:0] mem_m [int];
    int          ack_delay = 0;
    bit          ack_hold  = 1'b0;
    int          stall_cnt = 0;

    // Memory model: acks after ack_delay stall cycles, checks each access
    always @(negedge clk) begin
        acc_t e;
        if (mem_if.mem_read || mem_if.mem_write) begin
            if (mem_if.mem_read && mem_if.mem_write)
                check("strobe_overlap", 1'b1, 1'b0);
            if (!ack_hold && stall_cnt == ack_delay) begin
                mem_if.mem_ack = 1'b1;
                stall_cnt      = 0;
                if (exp_q.size() == 0) begin
                    check("unexpected_access", {mem_if.mem_write, mem_if.mem_addr}, '0);
                end else begin
                    e = exp_q.pop_front();
                    check("acc_kind", mem_if.mem_write, e.wr);
                    check("acc_addr", mem_if.mem_addr, e.addr);
                    if (e.wr) check("acc_wdata", mem_if.mem_wdata, e.wdata);
                end
                if (mem_if.mem_write) mem_m[int'(mem_if.mem_addr)] = mem_if.mem_wdata;
                mem_if.mem_rdata = mem_m.exists(int'(mem_if.mem_addr)) ?
                                   mem_m[int'(mem_if.mem_addr)] : 64'h0;
            end else begin
                mem_if.mem_ack   = 1'b0;
                mem_if.mem_rdata = '0;
                stall_cnt++;
            end
        end else begin
            mem_if.mem_ack   = 1'b0;
            mem_if.mem_rdata = '0;
            stall_cnt        = 0;
        end
    end

    function automatic logic [MA_W-1:0] baddr(input logic [ADDR_W-1:0] w);
        return MA_W'(w) << BS;
    endfunction

    // One transaction: push expectations, pulse start, measure latency
    task automatic run_txn(input string tag, input bit wr,
                           input logic [RD_CH*ADDR_W-1:0] ra,
                           input logic [WR_CH*ADDR_W-1:0] wa,
                           input logic [WR_CH*DATA_W-1:0] wd,
                           input int delay, input int exp_lat,
                           input logic [RDW-1:0] exp_rd, input bit restart);
        int   lat = 0;
        acc_t a;
        @(negedge clk);
        ack_delay = delay;
        if (wr) begin
            for (int k = 0; k < int'(WR_CH); k++) begin
                a.wr = 1'b1; a.addr = baddr(wa[k*ADDR_W +: ADDR_W]); a.wdata = wd[k*DATA_W +: DATA_W];
                exp_q.push_back(a);
            end
            wr_addr = wa; wr_data = wd; wr_start = 1'b1;
        end else begin
            for (int k = 0; k < int'(RD_CH); k++) begin
                a.wr = 1'b0; a.addr = baddr(ra[k*ADDR_W +: ADDR_W]); a.wdata = '0;
                exp_q.push_back(a);
            end
            rd_addr = ra; rd_start = 1'b1;
        end
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) begin
                check({tag, "_busy"}, busy, 1'b1);
                wr_start = 1'b0;
                rd_start = restart;
                rd_addr  = {11'h0AA, 11'h0BB, 11'h0CC};
                wr_addr  = '1;
                wr_data  = '1;
            end else begin
                rd_start = 1'b0;
            end
            if (done) begin
                lat = i;
                break;
            end
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_rd_data"}, rd_data, exp_rd);
        @(negedge clk);
        check({tag, "_done_width"}, done, 1'b0);
        check({tag, "_idle"}, {busy, err, mem_if.mem_read, mem_if.mem_write}, '0);
        check({tag, "_sb_empty"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    typedef struct {
        string                   tag;
        bit                      wr;
        logic [RD_CH*ADDR_W-1:0] ra;
        logic [WR_CH*ADDR_W-1:0] wa;
        logic [WR_CH*DATA_W-1:0] wd;
        int                      delay;
        int                      lat;
        logic [RDW-1:0]          exp_rd;
    } vec_t;

    vec_t vt[5];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        logic [RDW-1:0] prev_rd;

        vt[0] = '{"rd_nostall", 1'b0, {11'h7FF, 11'h010, 11'h001}, '0, '0, 0, 4,
                  {64'hC, 64'hB, 64'hA}};
        vt[1] = '{"wr_stall", 1'b1, '0, {11'd5, 11'd3}, {64'h2222, 64'h1111}, 2, 7,
                  {64'hC, 64'hB, 64'hA}};
        vt[2] = '{"rd_after_wr", 1'b0, {11'd5, 11'd3, 11'h001}, '0, '0, 1, 7,
                  {64'h2222, 64'h1111, 64'hA}};
        vt[3] = '{"wr_nostall", 1'b1, '0, {11'h7FF, 11'h000}, {V_DEAD, V_55AA}, 0, 3,
                  {64'h2222, 64'h1111, 64'hA}};
        vt[4] = '{"rd_edges", 1'b0, {11'h000, 11'h7FF, 11'h000}, '0, '0, 0, 4,
                  {V_55AA, V_DEAD, V_55AA}};

        mem_m[int'(14'h0008)] = 64'hA;
        mem_m[int'(14'h0080)] = 64'hB;
        mem_m[int'(14'h3FF8)] = 64'hC;

        reset = 1'b1; rd_start = 1'b0; wr_start = 1'b0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        mem_if.mem_ack = 1'b0; mem_if.mem_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_status", {busy, done, err}, '0);
        check("rst_strobes", {mem_if.mem_read, mem_if.mem_write}, '0);
        check("rst_addr", mem_if.mem_addr, '0);
        check("rst_wdata", mem_if.mem_wdata, '0);
        check("rst_rd_data", rd_data, '0);
        check("byte_enable", mem_if.mem_byte_enable, 8'hFF);
        reset = 1'b0;

        for (int v = 0; v < 5; v++)
            run_txn(vt[v].tag, vt[v].wr, vt[v].ra, vt[v].wa, vt[v].wd,
                    vt[v].delay, vt[v].lat, vt[v].exp_rd, 1'b0);

        // Both starts together: error pulse only
        @(negedge clk);
        rd_start = 1'b1; wr_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0; wr_start = 1'b0;
        check("both_err", err, 1'b1);
        check("both_quiet", {busy, done, mem_if.mem_read, mem_if.mem_write}, '0);
        @(negedge clk);
        check("both_err_width", err, 1'b0);
        check("both_busy", busy, 1'b0);

        // Restart during READ with changed rd_addr: ignored, snapshot used
        run_txn("rd_restart", 1'b0, {11'h001, 11'd5, 11'd3}, '0, '0, 1, 7,
                {64'hA, 64'h2222, 64'h1111}, 1'b1);

        // Reset in the middle of channel 1 of a read
        @(negedge clk);
        ack_delay = 2;
        begin
            acc_t a;
            for (int k = 0; k < 3; k++) begin
                a.wr = 1'b0; a.wdata = '0;
                a.addr = (k == 0) ? baddr(11'h004) : (k == 1) ? baddr(11'h020) : baddr(11'h100);
                exp_q.push_back(a);
            end
        end
        rd_addr = {11'h100, 11'h020, 11'h004}; rd_start = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rd_start = 1'b0;
            if (mem_if.mem_read && mem_if.mem_addr == baddr(11'h020)) begin
                found = 1'b1;
                reset = 1'b1;
                break;
            end
        end
        check("rst_mid_reached_ch1", found, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        check("rst_mid_status", {busy, done, err, mem_if.mem_read}, '0);
        check("rst_mid_addr", mem_if.mem_addr, '0);
        check("rst_mid_rd_data", rd_data, '0);
        repeat (2) begin
            @(negedge clk);
            check("rst_mid_no_done", done, 1'b0);
        end
        run_txn("rd_after_rst", 1'b0, {11'h7FF, 11'd5, 11'd3}, '0, '0, 0, 4,
                {V_DEAD, 64'h2222, 64'h1111}, 1'b0);
        prev_rd = rd_data;

`ifdef FFT_MEM_SEQ_TIMEOUT_EN
        // Ack never arrives: abort after TIMEOUT cycles
        @(negedge clk);
        ack_hold = 1'b1;
        rd_addr = {11'h001, 11'h002, 11'h003}; rd_start = 1'b1;
        for (int i = 1; i <= int'(TIMEOUT); i++) begin
            @(negedge clk);
            rd_start = 1'b0;
            check("to_waiting", {mem_if.mem_read, err, done}, 3'b100);
        end
        @(negedge clk);
        check("to_err", err, 1'b1);
        check("to_idle", {busy, done, mem_if.mem_read}, '0);
        @(negedge clk);
        check("to_err_width", {err, done}, '0);
        check("to_rd_kept", rd_data, {V_DEAD, 64'h2222, 64'h1111});
        ack_hold = 1'b0;
`else
        check("final_rd_kept", prev_rd, {V_DEAD, 64'h2222, 64'h1111});
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
